alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_if.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Issue/ALU/debug bundle between the issuing master and the issue controller.
interface alu_issue_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_data1;
  logic [7:0]  alu_data2;
  logic [2:0]  alu_select;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        done;
  logic        illegal;
  logic        zero_flag;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  // Issuer side: supplies instructions, the ALU response and debug address.
  modport master (
    output instr, instr_valid, alu_result, alu_zero, dbg_addr,
    input  instr_ready, alu_data1, alu_data2, alu_select, done, illegal,
           zero_flag, dbg_data
  );

  // Controller side.
  modport slave (
    input  instr, instr_valid, alu_result, alu_zero, dbg_addr,
    output instr_ready, alu_data1, alu_data2, alu_select, done, illegal,
           zero_flag, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: decodes one instruction at a time, drives
// snapshot operands to an external ALU for a fixed latency, then writes the
// ALU result back into an internal 8x8-bit register file.
module alu_issue_ctrl #(
  parameter int LAT_SHORT = 1,  // 1..15, latency of mov/loadi/and/or/srl
  parameter int LAT_ADD   = 2   // 1..15, latency of add/sub
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [3:0] LAT_S4 = 4'(LAT_SHORT);
  localparam logic [3:0] LAT_A4 = 4'(LAT_ADD);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic [7:0]      d1_q, d1_d, d2_q, d2_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      rd_q, rd_d;
  logic            done_q, done_d;
  logic            ill_q, ill_d;
  logic            zf_q, zf_d;

  // Instruction fields; only the low three bits of register fields matter.
  logic [7:0] opc, imm, r_t, r_s;
  logic [2:0] f_rd, f_rt, f_rs;
  logic       accept;

  assign opc    = bus.instr[31:24];
  assign f_rd   = bus.instr[18:16];
  assign f_rt   = bus.instr[10:8];
  assign f_rs   = bus.instr[2:0];
  assign imm    = bus.instr[7:0];
  assign r_t    = regs_q[f_rt];
  assign r_s    = regs_q[f_rs];
  assign accept = bus.instr_valid && (state_q == S_IDLE);

  logic       dec_legal;
  logic [2:0] dec_sel;
  logic [7:0] dec_d2;
  logic [3:0] dec_lat;

  // Opcode decode: ALU select, second operand and EXEC latency.
  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 3'b000;
    dec_d2    = imm;
    dec_lat   = LAT_S4;
    case (opc)
      8'h00: dec_d2 = imm;
      8'h01: dec_d2 = r_s;
      8'h02: begin dec_sel = 3'b001; dec_d2 = r_s;         dec_lat = LAT_A4; end
      8'h03: begin dec_sel = 3'b001; dec_d2 = ~r_s + 8'd1; dec_lat = LAT_A4; end
      8'h04: begin dec_sel = 3'b010; dec_d2 = r_s; end
      8'h05: begin dec_sel = 3'b011; dec_d2 = r_s; end
      8'h06: begin dec_sel = 3'b100; dec_d2 = imm; end
      default: dec_legal = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state. EXEC spends one cycle presenting operands and then counts
  // the latency down to zero, so an op occupies LAT+2 cycles in total.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && dec_legal) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == 4'd0)       state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.instr_ready = (state_q == S_IDLE);
    bus.alu_data1   = d1_q;
    bus.alu_data2   = d2_q;
    bus.alu_select  = sel_q;
    bus.done        = done_q;
    bus.illegal     = ill_q;
    bus.zero_flag   = zf_q;
    bus.dbg_data    = regs_q[bus.dbg_addr];
  end

  // Datapath next values: operand snapshot on accept, countdown, writeback.
  always_comb begin
    cnt_d  = cnt_q;
    regs_d = regs_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    sel_d  = sel_q;
    rd_d   = rd_q;
    zf_d   = zf_q;
    done_d = 1'b0;
    ill_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            d1_d  = r_t;
            d2_d  = dec_d2;
            sel_d = dec_sel;
            rd_d  = f_rd;
            cnt_d = dec_lat;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_EXEC: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      S_WB: begin
        regs_d[rd_q] = bus.alu_result;
        zf_d         = bus.alu_zero;
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      regs_q <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      sel_q  <= '0;
      rd_q   <= '0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      regs_q <= regs_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      sel_q  <= sel_d;
      rd_q   <= rd_d;
      done_q <= done_d;
      ill_q  <= ill_d;
      zf_q   <= zf_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU plus a transaction-level model
// of the register file, flag and ALU-output holding behaviour.
module tb_alu_issue_ctrl;
  localparam int LS = 1;
  localparam int LA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.LAT_SHORT(LS), .LAT_ADD(LA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural ALU.
  always_comb begin
    case (bus.alu_select)
      3'b000:  bus.alu_result = bus.alu_data2;
      3'b001:  bus.alu_result = bus.alu_data1 + bus.alu_data2;
      3'b010:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
      3'b011:  bus.alu_result = bus.alu_data1 | bus.alu_data2;
      3'b100:  bus.alu_result = 8'(bus.alu_data1 >> bus.alu_data2);
      default: bus.alu_result = 8'h00;
    endcase
    bus.alu_zero = (bus.alu_result == 8'h00);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_reg [8];
  logic       m_zf;
  logic [7:0] m_d1, m_d2;
  logic [2:0] m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_zf = 1'b0; m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'b000;
  endtask

  // Reads all eight registers over the debug port (8 time units).
  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'h0, bus.dbg_data}, {24'h0, m_reg[i]});
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] opc, input logic [7:0] rd,
                                     input logic [7:0] rt, input logic [7:0] rs);
    return {opc, rd, rt, rs};
  endfunction

  // Architectural result of an instruction.
  function automatic logic [7:0] ref_op(input logic [7:0] opc, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] imm);
    case (opc)
      8'h00:   return imm;
      8'h01:   return b;
      8'h02:   return a + b;
      8'h03:   return a - b;
      8'h04:   return a & b;
      8'h05:   return a | b;
      default: return 8'(a >> imm);
    endcase
  endfunction

  // Issue one instruction; entered and left on a falling edge.
  // hold keeps INSTR_VALID asserted (with junk INSTR) while the block is busy.
  task automatic issue(input logic [31:0] ins, input bit hold);
    logic [7:0] opc, a, b, imm, res, e_d2;
    logic [2:0] rd, e_sel;
    int lat, k;
    bit stable, busy;
    opc = ins[31:24]; rd = ins[18:16]; imm = ins[7:0];
    a = m_reg[ins[10:8]]; b = m_reg[ins[2:0]];
    chk("ready_pre", {31'h0, bus.instr_ready}, 32'h1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    if (opc > 8'h06) begin
      bus.instr_valid = 1'b0;
      chk("ill_pulse", {31'h0, bus.illegal}, 32'h1);
      chk("ill_done", {31'h0, bus.done}, 32'h0);
      chk("ill_ready", {31'h0, bus.instr_ready}, 32'h1);
      chk("ill_sel", {29'h0, bus.alu_select}, {29'h0, m_sel});
      chk("ill_d1", {24'h0, bus.alu_data1}, {24'h0, m_d1});
      chk("ill_d2", {24'h0, bus.alu_data2}, {24'h0, m_d2});
      chk("ill_zf", {31'h0, bus.zero_flag}, {31'h0, m_zf});
      check_regs("ill");
      @(negedge clk);
      chk("ill_clear", {31'h0, bus.illegal}, 32'h0);
      return;
    end
    lat   = (opc == 8'h02 || opc == 8'h03) ? LA : LS;
    e_sel = (opc == 8'h02 || opc == 8'h03) ? 3'b001 : (opc == 8'h04) ? 3'b010 :
            (opc == 8'h05) ? 3'b011 : (opc == 8'h06) ? 3'b100 : 3'b000;
    e_d2  = (opc == 8'h00 || opc == 8'h06) ? imm : (opc == 8'h03) ? 8'(0 - b) : b;
    res   = ref_op(opc, a, b, imm);
    if (hold) bus.instr = $urandom;
    else      bus.instr_valid = 1'b0;
    chk("sel", {29'h0, bus.alu_select}, {29'h0, e_sel});
    chk("d1", {24'h0, bus.alu_data1}, {24'h0, a});
    chk("d2", {24'h0, bus.alu_data2}, {24'h0, e_d2});
    chk("no_ill", {31'h0, bus.illegal}, 32'h0);
    // Writeback lands on edge E0+LAT+2, so DONE is seen at falling edge LAT+3.
    k = 1; stable = 1'b1; busy = 1'b1;
    while (!bus.done && k < 40) begin
      if (bus.alu_select !== e_sel || bus.alu_data1 !== a || bus.alu_data2 !== e_d2)
        stable = 1'b0;
      if (bus.instr_ready !== 1'b0) busy = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.instr_valid = 1'b0;
    chk("done_lat", 32'(k), 32'(lat + 3));
    chk("ops_stable", {31'h0, stable}, 32'h1);
    chk("busy", {31'h0, busy}, 32'h1);
    chk("ready_wb", {31'h0, bus.instr_ready}, 32'h1);
    m_reg[rd] = res; m_zf = (res == 8'h00);
    m_sel = e_sel; m_d1 = a; m_d2 = e_d2;
    chk("zf", {31'h0, bus.zero_flag}, {31'h0, m_zf});
    chk("hold_sel", {29'h0, bus.alu_select}, {29'h0, m_sel});
    chk("hold_d2", {24'h0, bus.alu_data2}, {24'h0, m_d2});
    check_regs("wb");
    @(negedge clk);
    chk("done_clear", {31'h0, bus.done}, 32'h0);
    chk("ready_post", {31'h0, bus.instr_ready}, 32'h1);
  endtask

  initial begin
    logic [7:0] ropc;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.dbg_addr = '0;
    model_reset();
    #3;
    chk("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_zf", {31'h0, bus.zero_flag}, 32'h0);
    check_regs("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    issue(mk(8'h00, 8'd1, 8'd0, 8'h05), 1'b0);   // loadi R1,5
    issue(mk(8'h00, 8'd2, 8'd0, 8'h03), 1'b0);   // loadi R2,3
    issue(mk(8'h02, 8'd3, 8'd1, 8'd2), 1'b1);    // add R3,R1,R2
    issue(mk(8'h03, 8'd4, 8'd1, 8'd1), 1'b0);    // sub R4,R1,R1 -> zero
    issue(mk(8'h05, 8'd5, 8'd1, 8'd2), 1'b0);    // or R5,R1,R2
    issue(mk(8'h7F, 8'd1, 8'd2, 8'd3), 1'b0);    // illegal
    issue(mk(8'h00, 8'd7, 8'd0, 8'hF0), 1'b0);   // loadi R7,F0
    issue(mk(8'h06, 8'd6, 8'd7, 8'h02), 1'b1);   // srl R6,R7,2
    issue(mk(8'h00, 8'd1, 8'd0, 8'h80), 1'b0);   // loadi R1,80
    issue(mk(8'h02, 8'd1, 8'd1, 8'd1), 1'b0);    // add R1,R1,R1 wraps

    // Reset in the middle of EXEC of add R3.
    bus.instr = mk(8'h02, 8'd3, 8'd1, 8'd2); bus.instr_valid = 1'b1;
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("arst_sel", {29'h0, bus.alu_select}, 32'h0);
    chk("arst_d1", {24'h0, bus.alu_data1}, 32'h0);
    chk("arst_d2", {24'h0, bus.alu_data2}, 32'h0);
    chk("arst_done", {31'h0, bus.done}, 32'h0);
    chk("arst_zf", {31'h0, bus.zero_flag}, 32'h0);
    check_regs("arst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue(mk(8'h00, 8'd3, 8'd0, 8'h5A), 1'b0);   // accepted on first edge

    for (int n = 0; n < 150; n++) begin
      ropc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(7, 255))
                                          : 8'($urandom_range(0, 6));
      issue({ropc, 24'($urandom)}, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
